region_bbox: RTL and testbench

- Sits directly downstream of the 3x3 binary erosion stage in the OV5640 -> SDRAM -> LCD480 pipeline.
- Consumes the eroded 1-bit pixel stream plus its sync/enable signals.
- Tracks the bounding box and pixel count of all foreground pixels in each frame, and latches the result at frame end.
- Re-emits the stream with a 1-cycle delay and a box-outline overlay flag, drawn from the last latched box, for LCD display.

---
 rtl/region_pkg.sv | 15 +
 rtl/frame_xy_counter.sv | 63 ++++++
 rtl/region_bbox.sv | 145 ++++++++++++++
 tb/tb_region_bbox.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/region_pkg.sv
// Shared defaults and accumulator seed values for the region bounding-box tracker.
package region_pkg;

    localparam int CW_DEF      = 10;
    localparam int NW_DEF      = 17;
    localparam int H_ACT_DEF   = 480;
    localparam int V_ACT_DEF   = 272;
    localparam int MIN_PIX_DEF = 64;

    // Min accumulators start at all ones so the first foreground pixel always wins;
    // max accumulators start at zero. Users truncate these to their coordinate width.
    localparam logic [31:0] MIN_ACC_INIT = '1;
    localparam logic [31:0] MAX_ACC_INIT = '0;

endpackage

// File: rtl/frame_xy_counter.sv
// Frame/line edge detection and pixel coordinate counters for the eroded stream.
module frame_xy_counter
    import region_pkg::*;
#(
    parameter int CW     = CW_DEF,
    parameter int H_ACT  = H_ACT_DEF,
    parameter int V_ACT  = V_ACT_DEF,
    parameter int VS_POL = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          vs,
    input  logic          de,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          fs,
    output logic          le
);

    localparam logic VS_LVL = (VS_POL != 0);

    logic vs_act;
    logic vs_act_d;
    logic de_d;

    assign vs_act = (vs == VS_LVL);
    assign fs     = vs_act & ~vs_act_d;
    assign le     = de_d & ~de;

    // Keep one-cycle copies of vsync activity and data enable for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_act_d <= 1'b0;
            de_d     <= 1'b0;
        end else begin
            vs_act_d <= vs_act;
            de_d     <= de;
        end
    end

    // Column counter: advance on every enabled pixel, restart at the end of each line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x <= '0;
        end else if (le) begin
            x <= '0;
        end else if (de && (x != CW'(H_ACT - 1))) begin
            x <= x + 1'b1;
        end
    end

    // Row counter: advance at each line end, restart at the start of each frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y <= '0;
        end else if (fs) begin
            y <= '0;
        end else if (le && (y != CW'(V_ACT - 1))) begin
            y <= y + 1'b1;
        end
    end

endmodule

// File: rtl/region_bbox.sv
// Foreground bounding-box tracker with a 1-clk video pass-through and box outline overlay.
module region_bbox
    import region_pkg::*;
#(
    parameter int H_ACT   = H_ACT_DEF,
    parameter int V_ACT   = V_ACT_DEF,
    parameter int CW      = CW_DEF,
    parameter int NW      = NW_DEF,
    parameter int MIN_PIX = MIN_PIX_DEF,
    parameter int VS_POL  = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          erode_vs,
    input  logic          erode_hs,
    input  logic          erode_de,
    input  logic          erode_data,
    output logic          bbox_vs,
    output logic          bbox_hs,
    output logic          bbox_de,
    output logic          bbox_data,
    output logic          bbox_edge,
    output logic          box_valid,
    output logic [CW-1:0] box_x_min,
    output logic [CW-1:0] box_x_max,
    output logic [CW-1:0] box_y_min,
    output logic [CW-1:0] box_y_max,
    output logic [NW-1:0] box_count,
    output logic          frame_done
);

    localparam logic [CW-1:0] COORD_MIN_INIT = CW'(MIN_ACC_INIT);
    localparam logic [CW-1:0] COORD_MAX_INIT = CW'(MAX_ACC_INIT);

    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          fs;
    logic          le;
    logic          fg;

    logic [CW-1:0] acc_x_min;
    logic [CW-1:0] acc_x_max;
    logic [CW-1:0] acc_y_min;
    logic [CW-1:0] acc_y_max;
    logic [NW-1:0] acc_cnt;

    logic x_on_side;
    logic y_on_side;
    logic x_in_span;
    logic y_in_span;
    logic edge_hit;

    frame_xy_counter #(
        .CW     (CW),
        .H_ACT  (H_ACT),
        .V_ACT  (V_ACT),
        .VS_POL (VS_POL)
    ) u_xy (
        .clk   (clk),
        .rst_n (rst_n),
        .vs    (erode_vs),
        .de    (erode_de),
        .x     (x),
        .y     (y),
        .fs    (fs),
        .le    (le)
    );

    // A pixel arriving in the frame-start cycle belongs to neither frame, so it is dropped.
    assign fg = erode_de & erode_data & ~fs;

    // Grow the running box and count over the frame; reseed at every frame start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_x_min <= COORD_MIN_INIT;
            acc_x_max <= COORD_MAX_INIT;
            acc_y_min <= COORD_MIN_INIT;
            acc_y_max <= COORD_MAX_INIT;
            acc_cnt   <= '0;
        end else if (fs) begin
            acc_x_min <= COORD_MIN_INIT;
            acc_x_max <= COORD_MAX_INIT;
            acc_y_min <= COORD_MIN_INIT;
            acc_y_max <= COORD_MAX_INIT;
            acc_cnt   <= '0;
        end else if (fg) begin
            if (x < acc_x_min) acc_x_min <= x;
            if (x > acc_x_max) acc_x_max <= x;
            if (y < acc_y_min) acc_y_min <= y;
            if (y > acc_y_max) acc_y_max <= y;
            if (acc_cnt != '1) acc_cnt <= acc_cnt + 1'b1;
        end
    end

    // Latch the finished frame's result at frame start; small blobs keep the old coordinates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            box_valid  <= 1'b0;
            box_x_min  <= '0;
            box_x_max  <= '0;
            box_y_min  <= '0;
            box_y_max  <= '0;
            box_count  <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= fs;
            if (fs) begin
                box_count <= acc_cnt;
                if (acc_cnt >= NW'(MIN_PIX)) begin
                    box_valid <= 1'b1;
                    box_x_min <= acc_x_min;
                    box_x_max <= acc_x_max;
                    box_y_min <= acc_y_min;
                    box_y_max <= acc_y_max;
                end else begin
                    box_valid <= 1'b0;
                end
            end
        end
    end

    assign x_on_side = (x == box_x_min) | (x == box_x_max);
    assign y_on_side = (y == box_y_min) | (y == box_y_max);
    assign x_in_span = (x >= box_x_min) & (x <= box_x_max);
    assign y_in_span = (y >= box_y_min) & (y <= box_y_max);
    assign edge_hit  = (x_on_side & y_in_span) | (y_on_side & x_in_span);

    // Delay the video stream one clock and mark pixels on the previously latched outline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bbox_vs   <= 1'b0;
            bbox_hs   <= 1'b0;
            bbox_de   <= 1'b0;
            bbox_data <= 1'b0;
            bbox_edge <= 1'b0;
        end else begin
            bbox_vs   <= erode_vs;
            bbox_hs   <= erode_hs;
            bbox_de   <= erode_de;
            bbox_data <= erode_data & erode_de;
            bbox_edge <= erode_de & box_valid & edge_hit;
        end
    end

endmodule

// File: tb/tb_region_bbox.sv
// Directed testbench for region_bbox using a reduced 128x64 frame and two MIN_PIX settings.
module tb_region_bbox;

    localparam int H  = 128;
    localparam int V  = 64;
    localparam int CW = 10;
    localparam int NW = 17;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic vs = 1'b0;
    logic hs = 1'b0;
    logic de = 1'b0;
    logic data = 1'b0;

    logic          a_vs, a_hs, a_de, a_data, a_edge, a_valid, a_done;
    logic [CW-1:0] a_x0, a_x1, a_y0, a_y1;
    logic [NW-1:0] a_cnt;
    logic          b_vs, b_hs, b_de, b_data, b_edge, b_valid, b_done;
    logic [CW-1:0] b_x0, b_x1, b_y0, b_y1;
    logic [NW-1:0] b_cnt;

    int vectors = 0;
    int miscompares = 0;
    int edge_seen = 0;
    int edge_wrong = 0;
    int vid_err = 0;

    logic draw_valid = 1'b0;
    int dx0 = 0, dx1 = 0, dy0 = 0, dy1 = 0;

    region_bbox #(.H_ACT(H), .V_ACT(V), .CW(CW), .NW(NW), .MIN_PIX(64), .VS_POL(1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .erode_vs(vs), .erode_hs(hs), .erode_de(de), .erode_data(data),
        .bbox_vs(a_vs), .bbox_hs(a_hs), .bbox_de(a_de), .bbox_data(a_data), .bbox_edge(a_edge),
        .box_valid(a_valid), .box_x_min(a_x0), .box_x_max(a_x1),
        .box_y_min(a_y0), .box_y_max(a_y1), .box_count(a_cnt), .frame_done(a_done)
    );

    region_bbox #(.H_ACT(H), .V_ACT(V), .CW(CW), .NW(NW), .MIN_PIX(1), .VS_POL(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .erode_vs(vs), .erode_hs(hs), .erode_de(de), .erode_data(data),
        .bbox_vs(b_vs), .bbox_hs(b_hs), .bbox_de(b_de), .bbox_data(b_data), .bbox_edge(b_edge),
        .box_valid(b_valid), .box_x_min(b_x0), .box_x_max(b_x1),
        .box_y_min(b_y0), .box_y_max(b_y1), .box_count(b_cnt), .frame_done(b_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic checkBox(input string tag, input bit inst, input int v, input int x0, input int x1,
                            input int y0, input int y1, input int cnt);
        if (!inst) begin
            checkOutput({tag, "_a_valid"}, 32'(a_valid), 32'(v));
            checkOutput({tag, "_a_xmin"},  32'(a_x0),    32'(x0));
            checkOutput({tag, "_a_xmax"},  32'(a_x1),    32'(x1));
            checkOutput({tag, "_a_ymin"},  32'(a_y0),    32'(y0));
            checkOutput({tag, "_a_ymax"},  32'(a_y1),    32'(y1));
            checkOutput({tag, "_a_count"}, 32'(a_cnt),   32'(cnt));
        end else begin
            checkOutput({tag, "_b_valid"}, 32'(b_valid), 32'(v));
            checkOutput({tag, "_b_xmin"},  32'(b_x0),    32'(x0));
            checkOutput({tag, "_b_xmax"},  32'(b_x1),    32'(x1));
            checkOutput({tag, "_b_ymin"},  32'(b_y0),    32'(y0));
            checkOutput({tag, "_b_ymax"},  32'(b_y1),    32'(y1));
            checkOutput({tag, "_b_count"}, 32'(b_cnt),   32'(cnt));
        end
    endtask

    function automatic bit pix(input int kind, input int x, input int y);
        int i;
        case (kind)
            1: return (x == 100) && (y == 50);
            2: return (x >= 10) && (x <= 29) && (y >= 20) && (y <= 29);
            3: begin
                if ((x % 2) == 0 || x > 99) return 1'b0;
                i = (x - 1) / 2;
                return y == 30 + (i % 8);
            end
            4: return 1'b1;
            5: return (y == 5) && (x < 70);
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit exp_edge(input int x, input int y);
        return draw_valid &&
               ((((x == dx0) || (x == dx1)) && (y >= dy0) && (y <= dy1)) ||
                (((y == dy0) || (y == dy1)) && (x >= dx0) && (x <= dx1)));
    endfunction

    // Send nlines active lines of the given pattern, tallying video-path and overlay observations.
    task automatic applyStimulus(input int kind, input int nlines);
        bit p;
        for (int yy = 0; yy < nlines; yy++) begin
            for (int xx = 0; xx < H; xx++) begin
                p = pix(kind, xx, yy);
                de = 1'b1;
                data = p;
                tick();
                if (a_de !== 1'b1 || a_data !== p) vid_err++;
                if (a_edge === 1'b1) edge_seen++;
                if (a_edge !== exp_edge(xx, yy)) edge_wrong++;
            end
            de = 1'b0;
            data = 1'b0;
            hs = 1'b1;
            tick();
            if (a_de !== 1'b0 || a_hs !== 1'b1 || a_edge !== 1'b0) vid_err++;
            hs = 1'b0;
            data = 1'b1;
            tick();
            if (a_data !== 1'b0 || a_hs !== 1'b0) vid_err++;
            data = 1'b0;
            tick();
            tick();
        end
    endtask

    task automatic frame_start(input bit fs_pixel);
        vs = 1'b1;
        de = fs_pixel;
        data = fs_pixel;
        tick();
        de = 1'b0;
        data = 1'b0;
        checkOutput("frame_done_pulse", 32'(a_done), 32'd1);
        checkOutput("bbox_vs_delay", 32'(a_vs), 32'd1);
    endtask

    task automatic frame_tail();
        tick();
        checkOutput("frame_done_single", 32'(a_done), 32'd0);
        vs = 1'b0;
        tick();
        tick();
        edge_seen = 0;
        edge_wrong = 0;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #2;
        checkBox("reset", 1'b0, 0, 0, 0, 0, 0, 0);
        checkOutput("reset_done", 32'(a_done), 32'd0);
        checkOutput("reset_de",   32'(a_de),   32'd0);
        #19 rst_n = 1'b1;
        tick();

        // Empty frame counted from reset
        frame_start(1'b0);
        checkBox("empty_reset_frame", 1'b0, 0, 0, 0, 0, 0, 0);
        frame_tail();
        draw_valid = 1'b0;
        applyStimulus(1, 51);

        // Single pixel at (100,50)
        frame_start(1'b0);
        checkBox("single_px", 1'b0, 0, 0, 0, 0, 0, 1);
        checkBox("single_px", 1'b1, 1, 100, 100, 50, 50, 1);
        frame_tail();
        applyStimulus(2, 32);
        checkOutput("no_outline_invalid", 32'(edge_seen), 32'd0);

        // 20x10 rectangle
        frame_start(1'b0);
        checkBox("rect", 1'b0, 1, 10, 29, 20, 29, 200);
        checkBox("rect", 1'b1, 1, 10, 29, 20, 29, 200);
        frame_tail();
        draw_valid = 1'b1;
        dx0 = 10; dx1 = 29; dy0 = 20; dy1 = 29;
        applyStimulus(3, 40);
        checkOutput("rect_outline_count", 32'(edge_seen), 32'd56);
        checkOutput("rect_outline_pos",   32'(edge_wrong), 32'd0);

        // 50 scattered pixels
        frame_start(1'b0);
        checkBox("scatter", 1'b0, 0, 10, 29, 20, 29, 50);
        checkBox("scatter", 1'b1, 1, 1, 99, 30, 37, 50);
        frame_tail();
        draw_valid = 1'b0;
        applyStimulus(4, V);
        checkOutput("scatter_no_outline", 32'(edge_seen), 32'd0);
        checkOutput("scatter_no_outline_pos", 32'(edge_wrong), 32'd0);

        // Full all-ones frame
        frame_start(1'b0);
        checkBox("full", 1'b0, 1, 0, H - 1, 0, V - 1, H * V);
        checkBox("full", 1'b1, 1, 0, H - 1, 0, V - 1, H * V);
        frame_tail();
        applyStimulus(0, 4);

        // All-zeros frame
        frame_start(1'b0);
        checkBox("zeros", 1'b0, 0, 0, H - 1, 0, V - 1, 0);
        frame_tail();
        applyStimulus(5, 6);

        // Pixel asserted in the frame-start cycle is dropped from both frames
        frame_start(1'b1);
        checkBox("fs_px_close", 1'b0, 1, 0, 69, 5, 5, 70);
        frame_tail();
        applyStimulus(0, 3);
        frame_start(1'b0);
        checkBox("fs_px_next", 1'b0, 0, 0, 69, 5, 5, 0);
        checkBox("fs_px_next", 1'b1, 0, 0, 69, 5, 5, 0);
        frame_tail();

        // Mid-frame asynchronous reset
        applyStimulus(2, 25);
        #2 rst_n = 1'b0;
        #1;
        checkBox("async_reset", 1'b0, 0, 0, 0, 0, 0, 0);
        checkOutput("async_reset_edge", 32'(a_edge), 32'd0);
        #3 rst_n = 1'b1;
        tick();
        applyStimulus(5, 6);
        frame_start(1'b0);
        checkBox("post_reset_partial", 1'b0, 1, 0, 69, 5, 5, 70);
        checkBox("post_reset_partial", 1'b1, 1, 0, 69, 5, 5, 70);
        frame_tail();
        applyStimulus(2, 32);
        frame_start(1'b0);
        checkBox("post_reset_rect", 1'b0, 1, 10, 29, 20, 29, 200);
        frame_tail();

        checkOutput("video_path", 32'(vid_err), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
